// File: rtl/sha256_pkg.sv
// +----------------------------------------------------------------------------+
// | sha256_pkg: constants, state encoding and sigma helpers shared by SHA-256  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sha256_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_msg_schedule_if.sv
// +----------------------------------------------------------------------------+
// | sha256_msg_schedule_if: word input stream and schedule output bundle       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sha256_msg_schedule_if;
  logic        valid_i;
  logic [31:0] M_i;
  logic        w_valid_o;
  logic [31:0] w_o;
  logic [5:0]  t_o;
  logic        last_o;
  logic        busy_o;
  logic        overflow_o;

  modport master (
    output valid_i, M_i,
    input  w_valid_o, w_o, t_o, last_o, busy_o, overflow_o
  );

  modport slave (
    input  valid_i, M_i,
    output w_valid_o, w_o, t_o, last_o, busy_o, overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/sha256_w_expand.sv
// +----------------------------------------------------------------------------+
// | sha256_w_expand: combinational W[t] from W[t-2], W[t-7], W[t-15], W[t-16]  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256_w_expand
  import sha256_pkg::*;
(
  input  wire logic [31:0] i_w2,
  input  wire logic [31:0] i_w7,
  input  wire logic [31:0] i_w15,
  input  wire logic [31:0] i_w16,
  output logic      [31:0] o_w
);

  assign o_w = sigma1(i_w2) + i_w7 + sigma0(i_w15) + i_w16;

endmodule

`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
// +----------------------------------------------------------------------------+
// | sha256_msg_schedule: loads 16 block words, then expands W[16..63]          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256_msg_schedule
  import sha256_pkg::*;
(
  input wire logic               clk,
  input wire logic               rst,
  sha256_msg_schedule_if.slave   bus
);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_buf [BLOCK_WORDS];
  logic [31:0] r_w;
  logic [5:0]  r_t;
  logic        r_wv;
  logic        r_last;
  logic        r_busy;
  logic        r_ovf;

  logic [3:0]  w_idx;
  logic [31:0] w_new;
  logic        w_last_word;
  logic        w_final;

  assign w_idx       = r_cnt[3:0];
  assign w_last_word = (r_state == LOAD) && bus.valid_i && (w_idx == 4'd15);
  assign w_final     = (r_state == EXPAND) && (r_cnt == 6'(ROUNDS - 1));

  // Circular buffer taps: slot i holds W[t-16]; the others are offsets mod 16.
  sha256_w_expand u_expand (
    .i_w2  (r_buf[w_idx + 4'd14]),
    .i_w7  (r_buf[w_idx + 4'd9]),
    .i_w15 (r_buf[w_idx + 4'd1]),
    .i_w16 (r_buf[w_idx]),
    .o_w   (w_new)
  );

  always_comb begin
    w_next = r_state;
    if (r_state == LOAD) begin
      if (w_last_word) w_next = EXPAND;
    end else begin
      if (w_final) w_next = LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_w    <= '0;
      r_t    <= '0;
      r_wv   <= 1'b0;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < BLOCK_WORDS; k++) r_buf[k] <= '0;
    end else begin
      r_wv   <= 1'b0;
      r_last <= 1'b0;
      if (r_state == LOAD) begin
        if (bus.valid_i) begin
          r_buf[w_idx] <= bus.M_i;
          r_w          <= bus.M_i;
          r_t          <= r_cnt;
          r_wv         <= 1'b1;
          r_cnt        <= r_cnt + 6'd1;
        end
      end else begin
        r_buf[w_idx] <= w_new;
        r_w          <= w_new;
        r_t          <= r_cnt;
        r_wv         <= 1'b1;
        r_last       <= w_final;
        r_cnt        <= w_final ? 6'd0 : r_cnt + 6'd1;
      end
      // Held through the cycle that presents W[63].
      r_busy <= (w_next == EXPAND) || (r_state == EXPAND);
      r_ovf  <= r_ovf | ((r_state == EXPAND) && bus.valid_i);
    end
  end

  assign bus.w_valid_o  = r_wv;
  assign bus.w_o        = r_w;
  assign bus.t_o        = r_t;
  assign bus.last_o     = r_last;
  assign bus.busy_o     = r_busy;
  assign bus.overflow_o = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// +----------------------------------------------------------------------------+
// | tb_sha256_msg_schedule: self-checking bench against a plain schedule model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];
  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_schedule_if bus();
  sha256_msg_schedule dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [31:0] cap_w[$];
  int          cap_t[$];
  bit          cap_last[$];
  bit          cap_busy[$];
  int          cap_cyc[$];

  always @(negedge clk) begin
    if (bus.w_valid_o) begin
      cap_w.push_back(bus.w_o);
      cap_t.push_back(int'(bus.t_o));
      cap_last.push_back(bus.last_o);
      cap_busy.push_back(bus.busy_o);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic clear_caps();
    cap_w.delete(); cap_t.delete(); cap_last.delete(); cap_busy.delete(); cap_cyc.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t model(input blk_t m);
    sched_t w;
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else begin
        s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
    end
    return w;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < 16; k++) b[k] = $urandom;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; mode 0 = back-to-back, 1 = alternate gaps, 2 = random gaps.
  task automatic load_block(input blk_t b, input int mode);
    for (int k = 0; k < 16; k++) begin
      bus.valid_i = 1'b1;
      bus.M_i     = b[k];
      step();
      if (k < 15 && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))) begin
        bus.valid_i = 1'b0;
        bus.M_i     = $urandom;
        repeat ((mode == 2) ? $urandom_range(1, 3) : 1) step();
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_words(input int n, input string name);
    int guard = 0;
    while (cap_w.size() < n && guard < 400) begin
      step();
      guard++;
    end
    chk({name, "_count"}, cap_w.size(), n);
  endtask

  task automatic wait_t(input int t, input string name);
    int guard = 0;
    while (!(bus.w_valid_o && int'(bus.t_o) == t) && guard < 200) begin
      step();
      guard++;
    end
    chk({name, "_reach_t"}, (guard < 200), 1);
  endtask

  task automatic check_sched(input blk_t b, input int base, input string name, input bit contig);
    sched_t exp = model(b);
    if (cap_w.size() < base + 64) return;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("%s_w%0d", name, k), cap_w[base+k], exp[k]);
      chk($sformatf("%s_t%0d", name, k), cap_t[base+k], k);
      chk($sformatf("%s_last%0d", name, k), cap_last[base+k], (k == 63));
      chk($sformatf("%s_busy%0d", name, k), cap_busy[base+k], (k >= 15));
      if (contig || k >= 15)
        chk($sformatf("%s_gap%0d", name, k), cap_cyc[base+k] - cap_cyc[base+k-((k>=15 && !contig) ? k-15 : k)],
            (contig ? k : k - 15));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_wvalid"}, bus.w_valid_o, 0);
    chk({name, "_w"}, bus.w_o, 0);
    chk({name, "_t"}, bus.t_o, 0);
    chk({name, "_last"}, bus.last_o, 0);
    chk({name, "_busy"}, bus.busy_o, 0);
  endtask

  initial begin
    blk_t abc, ba, bb, br;
    vec_t abc_vec[6];
    int guard;

    abc_vec[0] = '{0,  32'h61626380};
    abc_vec[1] = '{1,  32'h00000000};
    abc_vec[2] = '{14, 32'h00000000};
    abc_vec[3] = '{15, 32'h00000018};
    abc_vec[4] = '{16, 32'h61626380};
    abc_vec[5] = '{17, 32'h000F0000};
    for (int k = 0; k < 16; k++) abc[k] = 32'h0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;

    bus.valid_i = 1'b0;
    bus.M_i     = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    chk("reset_ovf", bus.overflow_o, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_nowords", cap_w.size(), 0);

    load_block(abc, 0);
    wait_words(64, "abc");
    check_sched(abc, 0, "abc", 1);
    if (cap_w.size() >= 64)
      for (int i = 0; i < 6; i++)
        chk($sformatf("abc_vec%0d", abc_vec[i].t), cap_w[abc_vec[i].t], abc_vec[i].w);

    step(); clear_caps();
    load_block(abc, 1);
    wait_words(64, "gap");
    check_sched(abc, 0, "gap", 0);
    if (cap_w.size() >= 2) chk("gap_spacing", cap_cyc[1] - cap_cyc[0], 2);

    step(); clear_caps();
    ba = rand_blk();
    bb = rand_blk();
    load_block(ba, 0);
    guard = 0;
    while (!bus.last_o && guard < 200) begin step(); guard++; end
    chk("b2b_last_seen", bus.last_o, 1);
    load_block(bb, 0);
    wait_words(128, "b2b");
    check_sched(ba, 0, "b2bA", 1);
    check_sched(bb, 64, "b2bB", 1);
    if (cap_w.size() >= 128) chk("b2b_seam", cap_cyc[64] - cap_cyc[63], 1);

    step(); clear_caps();
    load_block(abc, 0);
    wait_t(30, "ovf");
    chk("ovf_before", bus.overflow_o, 0);
    bus.valid_i = 1'b1;
    bus.M_i     = $urandom;
    step();
    bus.valid_i = 1'b0;
    chk("ovf_set", bus.overflow_o, 1);
    wait_words(64, "ovf");
    check_sched(abc, 0, "ovf", 1);
    repeat (5) step();
    chk("ovf_sticky", bus.overflow_o, 1);

    rst = 1'b1; step(); rst = 1'b0;
    chk("ovf_cleared", bus.overflow_o, 0);
    step(); clear_caps();
    load_block(rand_blk(), 0);
    wait_t(40, "mrst");
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("mrst");
    step();
    rst = 1'b0;
    step(); clear_caps();
    br = rand_blk();
    load_block(br, 0);
    wait_words(64, "post");
    check_sched(br, 0, "post", 1);

    for (int r = 0; r < 4; r++) begin
      step(); clear_caps();
      br = rand_blk();
      load_block(br, 2);
      wait_words(64, $sformatf("rnd%0d", r));
      check_sched(br, 0, $sformatf("rnd%0d", r), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
